mem_dump_tx: RTL and testbench

MEM_DUMP_TX -- requirements
Module: mem_dump_tx

---
 rtl/mem_dump_tx_pkg.sv | 22 ++
 rtl/mem_dump_tx.sv | 141 ++++++++++++++
 tb/tb_mem_dump_tx.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_dump_tx_pkg.sv
// mem_dump_tx_pkg: shared definitions for the memory dump transmitter.
// Holds the dump FSM state encoding, bank-select constants and the dump
// word width. Build option: MEM_DUMP_CHECKSUM_EN adds the CSUM state.
package mem_dump_tx_pkg;

    localparam int unsigned DUMP_WORD_W = 32;

    localparam logic BANK_DATA = 1'b0;
    localparam logic BANK_INST = 1'b1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        OUT  = 3'd3,
`ifdef MEM_DUMP_CHECKSUM_EN
        CSUM = 3'd5,
`endif
        DONE = 3'd4
    } dump_state_e;

endpackage

// File: rtl/mem_dump_tx.sv
// mem_dump_tx: streams the data bank then the instruction bank out over a
// valid/ready serial port, highest address first in each bank.
// Build option: define MEM_DUMP_CHECKSUM_EN to append a 32-bit XOR of all
// dumped words as one extra word before completion.
// Ports:
//   clk, rst (sync, active-low)
//   Jen        - serial-load enable; aborts any dump and holds idle
//   dump_req   - one-cycle start pulse
//   mem_rd_en, mem_sel, mem_addr, mem_rdata - bank read port (1-cycle latency)
//   Jout, Jout_valid, Jready                - serial output handshake
//   dump_busy, dump_done                    - status
module mem_dump_tx
    import mem_dump_tx_pkg::*;
#(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned AW    = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   Jen,
    input  logic                   dump_req,
    output logic                   mem_rd_en,
    output logic                   mem_sel,
    output logic [AW-1:0]          mem_addr,
    input  logic [DUMP_WORD_W-1:0] mem_rdata,
    output logic [DUMP_WORD_W-1:0] Jout,
    output logic                   Jout_valid,
    input  logic                   Jready,
    output logic                   dump_busy,
    output logic                   dump_done
);

    localparam logic [AW-1:0] ADDR_TOP = AW'(DEPTH - 1);

    // Address counting relies on the bank filling the full address space.
    if (DEPTH != (1 << AW)) begin : g_depth_chk
        $error("mem_dump_tx: DEPTH must equal 2**AW");
    end

    dump_state_e state;

`ifdef MEM_DUMP_CHECKSUM_EN
    logic [DUMP_WORD_W-1:0] csum;
`endif

    // Dump sequencer; every output is registered and set on state entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            Jout       <= '0;
            Jout_valid <= 1'b0;
            mem_rd_en  <= 1'b0;
            mem_sel    <= BANK_DATA;
            mem_addr   <= '0;
            dump_busy  <= 1'b0;
            dump_done  <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
            csum       <= '0;
`endif
        end else if (Jen) begin
            // Serial load owns the memories: drop the dump without completing.
            state      <= IDLE;
            Jout_valid <= 1'b0;
            mem_rd_en  <= 1'b0;
            dump_busy  <= 1'b0;
            dump_done  <= 1'b0;
        end else begin
            mem_rd_en <= 1'b0;
            dump_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (dump_req) begin
                        mem_sel   <= BANK_DATA;
                        mem_addr  <= ADDR_TOP;
                        mem_rd_en <= 1'b1;
                        dump_busy <= 1'b1;
                        state     <= RD;
`ifdef MEM_DUMP_CHECKSUM_EN
                        csum      <= '0;
`endif
                    end
                end
                RD: begin
                    state <= CAP;
                end
                CAP: begin
                    Jout       <= mem_rdata;
                    Jout_valid <= 1'b1;
                    state      <= OUT;
                end
                OUT: begin
                    if (Jready) begin
                        Jout_valid <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
                        csum       <= csum ^ Jout;
`endif
                        if (mem_addr == '0) begin
                            if (mem_sel == BANK_INST) begin
`ifdef MEM_DUMP_CHECKSUM_EN
                                // Fold in the word being accepted now.
                                Jout       <= csum ^ Jout;
                                Jout_valid <= 1'b1;
                                state      <= CSUM;
`else
                                dump_done  <= 1'b1;
                                state      <= DONE;
`endif
                            end else begin
                                mem_sel   <= BANK_INST;
                                mem_addr  <= ADDR_TOP;
                                mem_rd_en <= 1'b1;
                                state     <= RD;
                            end
                        end else begin
                            mem_addr  <= mem_addr - AW'(1);
                            mem_rd_en <= 1'b1;
                            state     <= RD;
                        end
                    end
                end
`ifdef MEM_DUMP_CHECKSUM_EN
                CSUM: begin
                    if (Jready) begin
                        Jout_valid <= 1'b0;
                        dump_done  <= 1'b1;
                        state      <= DONE;
                    end
                end
`endif
                DONE: begin
                    dump_busy <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_dump_tx.sv
// tb_mem_dump_tx: directed bench for mem_dump_tx with a behavioural memory,
// a scoreboard queue of expected words and a negedge output monitor.
module tb_mem_dump_tx;

    localparam int unsigned DEPTH = 512;
    localparam int unsigned AW    = 9;
`ifdef MEM_DUMP_CHECKSUM_EN
    localparam int unsigned NWORDS = 2 * DEPTH + 1;
    localparam int unsigned CYC    = 3 * 2 * DEPTH + 3;
`else
    localparam int unsigned NWORDS = 2 * DEPTH;
    localparam int unsigned CYC    = 3 * 2 * DEPTH + 2;
`endif

    logic          clk;
    logic          rst;
    logic          Jen;
    logic          dump_req;
    logic          mem_rd_en;
    logic          mem_sel;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rdata;
    logic [31:0]   Jout;
    logic          Jout_valid;
    logic          Jready;
    logic          dump_busy;
    logic          dump_done;

    logic [31:0] data_mem [DEPTH];
    logic [31:0] inst_mem [DEPTH];
    logic [31:0] exp_q [$];
    logic [31:0] last_word;

    int checks;
    int errors;
    int word_cnt;
    int done_cnt;

    mem_dump_tx #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .Jen        (Jen),
        .dump_req   (dump_req),
        .mem_rd_en  (mem_rd_en),
        .mem_sel    (mem_sel),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .Jout       (Jout),
        .Jout_valid (Jout_valid),
        .Jready     (Jready),
        .dump_busy  (dump_busy),
        .dump_done  (dump_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: read data returned one cycle after the strobe.
    always @(posedge clk) begin
        if (mem_rd_en)
            mem_rdata <= mem_sel ? inst_mem[mem_addr] : data_mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Monitor: a word is accepted at the next edge when valid && ready.
    always @(negedge clk) begin
        if (rst && !Jen && Jout_valid && Jready) begin
            if (exp_q.size() > 0)
                check("word", Jout, exp_q.pop_front());
            else
                check("extra_word_queue_size", 32'(exp_q.size()), 32'd1);
            last_word = Jout;
            word_cnt++;
        end
        if (rst && dump_done)
            done_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    // Inputs change just after the rising edge; outputs are stable then.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expected();
        logic [31:0] x;
        x = '0;
        for (int a = DEPTH - 1; a >= 0; a--) begin
            exp_q.push_back(data_mem[a]);
            x ^= data_mem[a];
        end
        for (int a = DEPTH - 1; a >= 0; a--) begin
            exp_q.push_back(inst_mem[a]);
            x ^= inst_mem[a];
        end
`ifdef MEM_DUMP_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_jout"},       Jout,                32'h0);
        check({tag, "_jout_valid"}, 32'(Jout_valid),     32'h0);
        check({tag, "_rd_en"},      32'(mem_rd_en),      32'h0);
        check({tag, "_sel"},        32'(mem_sel),        32'h0);
        check({tag, "_addr"},       32'(mem_addr),       32'h0);
        check({tag, "_busy"},       32'(dump_busy),      32'h0);
        check({tag, "_done"},       32'(dump_done),      32'h0);
    endtask

    // Returns in the first RD cycle; the request cycle counts as cycle 1.
    task automatic start_dump();
        exp_q.delete();
        word_cnt = 0;
        done_cnt = 0;
        push_expected();
        dump_req = 1'b1;
        step();
        dump_req = 1'b0;
        check("start_addr",  32'(mem_addr),  32'(DEPTH - 1));
        check("start_sel",   32'(mem_sel),   32'h0);
        check("start_rd_en", 32'(mem_rd_en), 32'h1);
        check("start_busy",  32'(dump_busy), 32'h1);
    endtask

    task automatic wait_words(input int n);
        int t;
        t = 0;
        while (word_cnt < n && t < 5000) begin
            step();
            t++;
        end
        check("wait_words", 32'(word_cnt), 32'(n));
    endtask

    // mode 0: plain, timed; mode 1: stall on word 3; mode 2: extra dump_req.
    task automatic run_dump(input int mode);
        int  cycles;
        bit  stalled;
        bit  extra;
        stalled = 1'b0;
        extra   = 1'b0;
        start_dump();
        cycles = 2;
        while (!dump_done && cycles < 4000) begin
            dump_req = 1'b0;
            if (mode == 1 && word_cnt == 3 && !stalled && !Jout_valid) begin
                Jready = 1'b0;
                step();
                step();
                cycles += 2;
                for (int i = 0; i < 5; i++) begin
                    check("stall_valid", 32'(Jout_valid), 32'h1);
                    check("stall_hold",  Jout,            32'h0000_01FC);
                    step();
                    cycles++;
                end
                Jready  = 1'b1;
                stalled = 1'b1;
            end
            if (mode == 2 && word_cnt == 100 && !extra) begin
                dump_req = 1'b1;
                extra    = 1'b1;
            end
            step();
            cycles++;
        end
        dump_req = 1'b0;
        check("dump_done_seen", 32'(dump_done), 32'h1);
        if (mode == 0)
            check("req_to_done_cycles", 32'(cycles), 32'(CYC));
        step();
        check("word_count",   32'(word_cnt),     32'(NWORDS));
        check("done_pulses",  32'(done_cnt),     32'h1);
        check("queue_empty",  32'(exp_q.size()), 32'h0);
        check("end_busy",     32'(dump_busy),    32'h0);
        check("end_done_low", 32'(dump_done),    32'h0);
    endtask

    initial begin
        int t;
        checks   = 0;
        errors   = 0;
        word_cnt = 0;
        done_cnt = 0;
        rst      = 1'b0;
        Jen      = 1'b0;
        dump_req = 1'b0;
        Jready   = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            data_mem[k] = 32'(k);
            inst_mem[k] = 32'h1000 + 32'(k);
        end

        repeat (3) step();
        check_reset_outputs("reset");
        rst = 1'b1;
        step();

        // Full dump at one word per three cycles.
        run_dump(0);

        // Ready held low while word 3 (0x1FC) is presented.
        run_dump(1);

        // Abort by Jen while word 700 is presented.
        start_dump();
        wait_words(700);
        Jready = 1'b0;
        t = 0;
        while (!Jout_valid && t < 10) begin
            step();
            t++;
        end
        check("jen_word", Jout, 32'h1000 + 32'(DEPTH - 1 - (700 - DEPTH)));
        Jen = 1'b1;
        step();
        check("jen_valid_low", 32'(Jout_valid), 32'h0);
        check("jen_busy_low",  32'(dump_busy),  32'h0);
        check("jen_rd_en_low", 32'(mem_rd_en),  32'h0);
        Jen    = 1'b0;
        Jready = 1'b1;
        exp_q.delete();
        repeat (10) step();
        check("jen_no_done", 32'(done_cnt), 32'h0);
        run_dump(0);

        // Reset for one edge during word 10.
        start_dump();
        wait_words(10);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check_reset_outputs("midreset");
        exp_q.delete();
        step();
        run_dump(0);

        // Second request while busy is ignored.
        run_dump(2);

`ifdef MEM_DUMP_CHECKSUM_EN
        for (int k = 0; k < DEPTH; k++) begin
            data_mem[k] = 32'h0;
            inst_mem[k] = 32'h0;
        end
        data_mem[5] = 32'h3E8;
        run_dump(0);
        check("csum_word", last_word, 32'h0000_03E8);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
